// File: rtl/uart_mmio_ctrl.sv
// UART MMIO window controller with TX/RX byte FIFOs; UART_STATUS_EXT_EN adds an extended status register at 0x8000_0010.
// Latency: load data is registered and appears 1 cycle after MemRead; FIFO heads are combinational from the arrays.
// Backpressure: TX stores to a full FIFO are dropped (sticky tx_ovf); RX ready drops while the RX FIFO is full.

module uart_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_vld,
    input  logic [7:0]     push_dat,
    input  logic           pop_vld,
    output logic           push_ok,
    output logic [7:0]     head_dat,
    output logic [PTR_W:0] count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_eff, push_eff;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    always_comb begin
        pop_eff  = pop_vld && (count_q != '0);
        push_eff = push_vld && ((count_q != FULL_CNT) || pop_eff);
        push_ok  = push_eff;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_eff);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
        count_d  = count_q + (PTR_W + 1)'(push_eff) - (PTR_W + 1)'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module uart_mmio_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [7:0]  WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  UARTDataIn,
    output logic        UARTDataInValid,
    input  logic        UARTDataInReady,
    input  logic [7:0]  UARTDataOut,
    input  logic        UARTDataOutValid,
    output logic        UARTDataOutReady
);
    localparam logic [31:0]    ADDR_TX_RDY = 32'h8000_0000;
    localparam logic [31:0]    ADDR_RX_VLD = 32'h8000_0004;
    localparam logic [31:0]    ADDR_TX_DAT = 32'h8000_0008;
    localparam logic [31:0]    ADDR_RX_DAT = 32'h8000_000C;
    localparam logic [PTR_W:0] FULL_CNT    = (PTR_W + 1)'(FIFO_DEPTH);

    logic           rd_req, wr_req;
    logic           tx_push_vld, tx_push_ok, tx_pop_vld;
    logic           rx_push_vld, rx_pop_vld, rx_push_unused;
    logic [7:0]     tx_head_dat, rx_head_dat;
    logic [PTR_W:0] tx_count, rx_count;
    logic [31:0]    read_data_q, read_data_d;
    logic           tx_ovf_q, tx_ovf_d;

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (tx_push_vld),
        .push_dat (WriteData),
        .pop_vld  (tx_pop_vld),
        .push_ok  (tx_push_ok),
        .head_dat (tx_head_dat),
        .count    (tx_count)
    );

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (rx_push_vld),
        .push_dat (UARTDataOut),
        .pop_vld  (rx_pop_vld),
        .push_ok  (rx_push_unused),
        .head_dat (rx_head_dat),
        .count    (rx_count)
    );

    assign UARTDataInValid  = (tx_count != '0);
    assign UARTDataIn       = tx_head_dat;
    assign UARTDataOutReady = (rx_count != FULL_CNT);
    assign tx_pop_vld       = UARTDataInValid && UARTDataInReady;
    assign rx_push_vld      = UARTDataOutValid && UARTDataOutReady;
    assign ReadData         = read_data_q;

`ifdef UART_STATUS_EXT_EN
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0010;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       rx_stall;
`else
    logic unused_tx_ovf;
    assign unused_tx_ovf = tx_ovf_q;
`endif

    always_comb begin
        wr_req      = MemWrite;
        rd_req      = MemRead && !MemWrite;
        tx_push_vld = wr_req && (Address == ADDR_TX_DAT);
        rx_pop_vld  = rd_req && (Address == ADDR_RX_DAT);
        tx_ovf_d    = tx_ovf_q;
        if (tx_push_vld && !tx_push_ok) tx_ovf_d = 1'b1;
`ifdef UART_STATUS_EXT_EN
        // Overrun flags a receiver stalled against a full FIFO for 256 straight cycles.
        rx_stall    = UARTDataOutValid && !UARTDataOutReady;
        stall_cnt_d = rx_stall ? stall_cnt_q + 8'd1 : 8'd0;
        rx_ovr_d    = rx_ovr_q || (rx_stall && (stall_cnt_q == 8'hFF));
        if (wr_req && (Address == ADDR_STATUS)) begin
            tx_ovf_d = 1'b0;
            rx_ovr_d = 1'b0;
        end
`endif
        read_data_d = read_data_q;
        if (rd_req) begin
            read_data_d = '0;
            case (Address)
                ADDR_TX_RDY: read_data_d = {31'b0, tx_count != FULL_CNT};
                ADDR_RX_VLD: read_data_d = {31'b0, rx_count != '0};
                ADDR_RX_DAT: read_data_d = {24'b0, (rx_count != '0) ? rx_head_dat : 8'h00};
`ifdef UART_STATUS_EXT_EN
                ADDR_STATUS: read_data_d = {16'b0, tx_ovf_q, 3'b0, 4'(tx_count),
                                            rx_ovr_q, 3'b0, 4'(rx_count)};
`endif
                default:     read_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= '0;
            tx_ovf_q    <= 1'b0;
`ifdef UART_STATUS_EXT_EN
            stall_cnt_q <= '0;
            rx_ovr_q    <= 1'b0;
`endif
        end else begin
            read_data_q <= read_data_d;
            tx_ovf_q    <= tx_ovf_d;
`ifdef UART_STATUS_EXT_EN
            stall_cnt_q <= stall_cnt_d;
            rx_ovr_q    <= rx_ovr_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: vector table for decode and basic TX flow, hand sequences for FIFO corners.
module tb_uart_mmio_ctrl;
    localparam logic [31:0] A0  = 32'h8000_0000;
    localparam logic [31:0] A4  = 32'h8000_0004;
    localparam logic [31:0] A8  = 32'h8000_0008;
    localparam logic [31:0] AC  = 32'h8000_000C;
    localparam logic [31:0] A10 = 32'h8000_0010;
    localparam logic [31:0] A14 = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic        MemRead, MemWrite;
    logic [7:0]  WriteData;
    logic [31:0] ReadData;
    logic [7:0]  UARTDataIn;
    logic        UARTDataInValid, UARTDataInReady;
    logic [7:0]  UARTDataOut;
    logic        UARTDataOutValid, UARTDataOutReady;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_mmio_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .Address          (Address),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .WriteData        (WriteData),
        .ReadData         (ReadData),
        .UARTDataIn       (UARTDataIn),
        .UARTDataInValid  (UARTDataInValid),
        .UARTDataInReady  (UARTDataInReady),
        .UARTDataOut      (UARTDataOut),
        .UARTDataOutValid (UARTDataOutValid),
        .UARTDataOutReady (UARTDataOutReady)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdat;
        logic        tx_rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_txv;
        logic [7:0]  exp_txd;
        logic        exp_rxr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic rd, logic wr, logic [31:0] addr, logic [7:0] wdat,
                                logic tx_rdy, logic chk_rd, logic [31:0] exp_rd,
                                logic exp_txv, logic [7:0] exp_txd, logic exp_rxr);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat; v.tx_rdy = tx_rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_txv = exp_txv; v.exp_txd = exp_txd;
        v.exp_rxr = exp_rxr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        idle(); MemRead = 1'b1; Address = a;
        tick(); idle();
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        idle(); MemWrite = 1'b1; Address = a; WriteData = d;
        tick(); idle();
    endtask

    // Drains the TX FIFO with ready held high, checking each byte and the total.
    task automatic drain(input logic [7:0] first, input int n, input string nm);
        int got = 0;
        UARTDataInReady = 1'b1;
        for (int c = 0; c < 40 && UARTDataInValid; c++) begin
            chk($sformatf("%s byte%0d", nm, got), {24'b0, UARTDataIn}, {24'b0, 8'(int'(first) + got)});
            got++;
            tick();
        end
        UARTDataInReady = 1'b0;
        chk($sformatf("%s count", nm), got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; idle();
        UARTDataInReady = 1'b0; UARTDataOut = '0; UARTDataOutValid = 1'b0;
        tick();

        //          rst rd wr addr          wdat   txr chk exp_rd txv txd    rxr
        tbl.push_back(mk(1, 0, 0, 32'h0, 8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A14,   8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0, 8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A8,    8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, 32'h0, 8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, AC,    8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A10,   8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A4,    8'h00, 0, 1, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 1, A8,    8'h41, 0, 1, 32'd1, 1, 8'h41, 1));
        tbl.push_back(mk(0, 0, 1, A8,    8'h42, 0, 0, 32'd0, 1, 8'h41, 1));
        tbl.push_back(mk(0, 1, 1, A8,    8'h43, 0, 1, 32'd1, 1, 8'h41, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 1, 8'h41, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0, 8'h00, 1, 0, 32'd0, 1, 8'h42, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0, 8'h00, 1, 0, 32'd0, 1, 8'h43, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0, 8'h00, 1, 0, 32'd0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 1, 0, A0,    8'h00, 0, 1, 32'd1, 0, 8'h00, 1));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; MemRead = tbl[i].rd; MemWrite = tbl[i].wr;
            Address = tbl[i].addr; WriteData = tbl[i].wdat; UARTDataInReady = tbl[i].tx_rdy;
            tick();
            if (tbl[i].chk_rd) chk($sformatf("row%0d ReadData", i), ReadData, tbl[i].exp_rd);
            chk($sformatf("row%0d txv", i), {31'b0, UARTDataInValid}, {31'b0, tbl[i].exp_txv});
            if (tbl[i].exp_txv) chk($sformatf("row%0d txd", i), {24'b0, UARTDataIn}, {24'b0, tbl[i].exp_txd});
            chk($sformatf("row%0d rxr", i), {31'b0, UARTDataOutReady}, {31'b0, tbl[i].exp_rxr});
        end
        reset = 1'b0; idle(); UARTDataInReady = 1'b0;

        // TX overflow: ninth byte dropped
        for (int i = 0; i < 9; i++) bus_wr(A8, 8'(8'h50 + i));
        bus_rd(A0); chk("ovf tx_rdy", ReadData, 32'd0);
`ifdef UART_STATUS_EXT_EN
        bus_rd(A10); chk("ovf ext status", ReadData, 32'h0000_8800);
`endif
        drain(8'h50, 8, "ovf drain");
        bus_rd(A0); chk("ovf tx_rdy after drain", ReadData, 32'd1);
`ifdef UART_STATUS_EXT_EN
        bus_wr(A10, 8'h00);
        bus_rd(A10); chk("ext status cleared", ReadData, 32'd0);
`endif

        // Full TX FIFO: push in the same cycle the UART pops
        for (int i = 0; i < 8; i++) bus_wr(A8, 8'(8'h60 + i));
        UARTDataInReady = 1'b1; MemWrite = 1'b1; Address = A8; WriteData = 8'h68;
        tick();
        UARTDataInReady = 1'b0; idle();
        chk("simul head", {24'b0, UARTDataIn}, 32'h61);
        bus_rd(A0); chk("simul still full", ReadData, 32'd0);
`ifdef UART_STATUS_EXT_EN
        bus_rd(A10); chk("simul no ovf", ReadData, 32'h0000_0800);
`endif
        drain(8'h61, 8, "simul drain");

        // RX fill: status read sees count before the same-cycle push
        UARTDataOutValid = 1'b1; UARTDataOut = 8'h10; MemRead = 1'b1; Address = A4;
        tick(); idle();
        chk("rx status pre-push", ReadData, 32'd0);
        for (int i = 1; i < 8; i++) begin
            UARTDataOut = 8'(8'h10 + i);
            chk($sformatf("rx rdy before push%0d", i), {31'b0, UARTDataOutReady}, 32'd1);
            tick();
        end
        chk("rx rdy full", {31'b0, UARTDataOutReady}, 32'd0);
        UARTDataOut = 8'h99;
        tick();
        chk("rx rdy stays low", {31'b0, UARTDataOutReady}, 32'd0);
        bus_rd(A4); chk("rx status full", ReadData, 32'd1);
        // Pop while full and valid high: slot frees but that push is refused
        MemRead = 1'b1; Address = AC;
        tick(); idle();
        UARTDataOutValid = 1'b0;
        chk("rx pop0", ReadData, 32'h10);
        chk("rx rdy after pop", {31'b0, UARTDataOutReady}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            bus_rd(AC); chk($sformatf("rx pop%0d", i), ReadData, 32'(8'h10 + i));
        end
        bus_rd(AC); chk("rx pop empty", ReadData, 32'd0);
        bus_rd(A4); chk("rx status empty", ReadData, 32'd0);

        // Reset with three bytes in each FIFO and a load in flight
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; Address = A8; WriteData = 8'(8'h70 + i);
            UARTDataOutValid = 1'b1; UARTDataOut = 8'(8'h80 + i);
            tick();
        end
        idle(); UARTDataOutValid = 1'b0;
        chk("pre-rst txv", {31'b0, UARTDataInValid}, 32'd1);
        bus_rd(A4); chk("pre-rst rx status", ReadData, 32'd1);
        reset = 1'b1; MemRead = 1'b1; Address = A0;
        tick();
        reset = 1'b0; idle();
        chk("rst txv", {31'b0, UARTDataInValid}, 32'd0);
        chk("rst rxr", {31'b0, UARTDataOutReady}, 32'd1);
        chk("rst ReadData", ReadData, 32'd0);
        bus_rd(A4); chk("post-rst rx status", ReadData, 32'd0);
        UARTDataOutValid = 1'b1; UARTDataOut = 8'hA5;
        tick();
        UARTDataOutValid = 1'b0;
        bus_rd(AC); chk("post-rst rx first byte", ReadData, 32'hA5);
        bus_rd(A0); chk("post-rst tx_rdy", ReadData, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
